// File: rtl/cp0_unit_if.sv
// Pipeline <-> coprocessor-0 signal bundle.
// The pipeline (M stage plus memory bridge) is the master; cp0_unit is the slave.
interface cp0_unit_if;
    logic [4:0]  A;        // CP0 register number for mfc0/mtc0
    logic [31:0] DIn;      // mtc0 write data
    logic        WE;       // mtc0 write enable
    logic        EXLClr;   // eret commit
    logic [31:0] PC;       // PC of the instruction in M
    logic        BD;       // M instruction is in a branch delay slot
    logic [4:0]  ExcCode;  // pending exception code, 0 = none
    logic [5:0]  HWInt;    // hardware interrupt lines
    logic [31:0] DOut;     // mfc0 read data
    logic [31:0] EPCOut;   // current EPC for eret
    logic        Req;      // take interrupt/exception this cycle

    modport master (
        output A, DIn, WE, EXLClr, PC, BD, ExcCode, HWInt,
        input  DOut, EPCOut, Req
    );

    modport slave (
        input  A, DIn, WE, EXLClr, PC, BD, ExcCode, HWInt,
        output DOut, EPCOut, Req
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC and PRId, interrupt/exception request
// evaluation, victim-PC capture and the mfc0/mtc0/eret service for the M stage.
module cp0_unit #(
    parameter logic [31:0] PRID       = 32'h2022_1129,
    // Handler entry the pipeline redirects to when Req is high; kept here so
    // the address lives next to the logic that raises Req.
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic       clk,
    input  logic       reset,
    cp0_unit_if.slave  bus
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Only the implemented fields are stored; everything else reads as 0.
    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [29:0] epc_q,       epc_d;      // word address; bits 1:0 are always 0

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [29:0] pc_word;
    logic [29:0] victim_word;

    // Request evaluation uses the live HWInt, not the delayed Cause.IP copy.
    always_comb begin
        int_req     = (|(bus.HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
        exc_req     = (bus.ExcCode != 5'd0) & ~sr_exl_q;
        req         = int_req | exc_req;
        pc_word     = bus.PC[31:2];
        // A delay-slot victim restarts at its branch, one word earlier.
        victim_word = bus.BD ? (pc_word - 30'd1) : pc_word;
    end

    // Next-state for all CP0 state: exception entry overrides mtc0 and eret.
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        cause_ip_d  = bus.HWInt;

        if (req) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? 5'd0 : bus.ExcCode;
            cause_bd_d  = bus.BD;
            epc_d       = victim_word;
        end else begin
            if (bus.WE && bus.A == REG_SR) begin
                sr_im_d  = bus.DIn[15:10];
                sr_exl_d = bus.DIn[1];
                sr_ie_d  = bus.DIn[0];
            end
            if (bus.WE && bus.A == REG_EPC) begin
                epc_d = bus.DIn[31:2];
            end
            // eret has the last word on EXL even if SR is written together.
            if (bus.EXLClr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 30'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // mfc0 read mux straight from the stored registers (no write-through).
    always_comb begin
        bus.DOut = 32'd0;
        unique case (bus.A)
            REG_SR:    bus.DOut = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
            REG_CAUSE: bus.DOut = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
            REG_EPC:   bus.DOut = {epc_q, 2'b00};
            REG_PRID:  bus.DOut = PRID;
            default:   bus.DOut = 32'd0;
        endcase
    end

    // Remaining outputs.
    always_comb begin
        bus.EPCOut = {epc_q, 2'b00};
        bus.Req    = req;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block that consumes the memory-bridge outputs: the 5-bit exception code and the two timer interrupt lines, plus the interrupt-generator line.
- Holds SR, Cause, EPC and PRId, and evaluates the interrupt/exception request.
- Records the victim PC, and serves mfc0/mtc0/eret from the M stage.
- The pipeline flushes and redirects to the handler whenever Req is high.

Parameters:
PRID, 32'h2022_1129, read-only value returned for register 15
HANDLER_PC, 32'h0000_4180, informational handler entry (not used internally; documented for the pipeline)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
A  input  5  CP0 register number for read (mfc0) and write (mtc0)
DIn  input  32  mtc0 write data
WE  input  1  mtc0 write enable
EXLClr  input  1  eret commit; clears SR.EXL
PC  input  32  PC of the instruction currently in M
BD  input  1  M instruction sits in a branch delay slot
ExcCode  input  5  exception code from the bridge / earlier stages; 0 = none
HWInt  input  6  hardware interrupts: bit0 TC0_inter, bit1 TC1_inter, bit2 interrupt-generator, bits 5:3 tie 0
DOut  output  32  mfc0 read data for register A
EPCOut  output  32  current EPC, used by eret
Req  output  1  take interrupt/exception this cycle

Behaviour:

Register fields:
- SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0. Cause is read-only to mtc0.
- EPC (14): 32 bits, bits 1:0 always 0.
- PRId (15): PRID.
- Any other A value reads 0, and writes to it are ignored.

Reset:
- On a clk edge with reset=1, SR, Cause and EPC are all 0.
- Outputs then read DOut=0 (for A≠15), EPCOut=0, Req=0.

Request logic (combinational, same cycle):
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCode != 0) & ~SR.EXL.
- Req = IntReq | ExcReq.
- Interrupts take priority over exceptions.

Actions on a clk edge when Req=1:
- SR.EXL <= 1.
- Cause.ExcCode <= IntReq ? 0 : ExcCode.
- Cause.BD <= BD.
- EPC <= BD ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
- A coincident mtc0 (WE) is suppressed: the victim instruction does not commit.
- A coincident EXLClr is ignored.

Every cycle, independent of Req:
- Cause.IP <= HWInt.
- IP is therefore a 1-cycle-delayed mirror; the request logic uses live HWInt.

Actions on a clk edge when Req=0:
- If EXLClr=1, SR.EXL <= 0.
- If WE=1 and A=12: SR.IM <= DIn[15:10], SR.EXL <= DIn[1], SR.IE <= DIn[0].
- If WE=1 and A=14: EPC <= {DIn[31:2],2'b00}.
- If EXLClr and an mtc0 to SR occur in the same cycle, EXLClr wins for the EXL bit; the write still sets IM and IE.

Read path:
- DOut is combinational from A and reflects current register contents (no write-through bypass).
- EPCOut is the registered EPC, not bypassed.

Nesting:
- While EXL=1, Req is held 0 regardless of HWInt or ExcCode.
- A pending interrupt fires on the first cycle after EXL clears, if it is still asserted and enabled.

Latency:
- Req is 0-cycle (combinational).
- State updates are visible on the cycle after the edge.

Test Plan:
- Reset then mtc0 A=12 DIn=32'h0000_0401 -> next cycle DOut(A=12)=32'h0000_0401; assert HWInt=6'b000001 -> Req=1 same cycle; after the edge with PC=32'h0000_3010, BD=0: EPC=32'h0000_3010, SR.EXL=1, Cause.ExcCode=0, Req=0.
- SR=0 (IE=0), ExcCode=5'd4 (AdEL from the bridge), PC=32'h0000_3024, BD=1 -> Req=1; after the edge EPC=32'h0000_3020, Cause=32'h8000_0010.
- HWInt=6'b000010 with IM=6'b000001, IE=1 -> Req=0; one cycle later Cause.IP=6'b000010 (DOut(A=13)=32'h0000_0800).
- EXL=1, ExcCode=5'd5 and HWInt enabled -> Req=0; EXLClr=1 for one cycle -> EXL=0 and Req=1 on the following cycle.
- Req=1 coincident with WE=1, A=14, DIn=32'hDEAD_BEEF -> EPC equals the victim PC, not 32'hDEAD_BEEC.
- Read A=15 -> DOut=32'h2022_1129; read A=7 -> 0; mtc0 A=13 DIn=32'hFFFF_FFFF -> Cause unchanged; reset asserted mid-handler (EXL=1) -> SR, Cause and EPC return to 0 on that edge.
